// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the single register-file write port between the ALU writeback (src0)
// and the load writeback (src1). Each source owns a one-entry holding slot.
// A round-robin/age arbiter drains the slots onto the write port, one write per
// cycle. A pending-write scoreboard flags decode reads that hit an unretired write.
// Optional feature: define REGARB_FWD_EN to add write-stage forwarding outputs
// (FwdAVld/FwdA, FwdBVld/FwdB). A write-stage-only hit then forwards instead of stalling.
//
// Handshake: a source write transfers on a posedge where VldN & RdyN are both 1.
// RdyN is combinational from slot state only (never from VldN), and is 1 when the
// slot is empty or is being granted this cycle. Data/address are sampled on that edge.
module regfile_write_arbiter #(
   parameter int AW = 5,
   parameter int DW = 32
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          Vld0,
   input  logic [AW-1:0] Addr0,
   input  logic [DW-1:0] Data0,
   input  logic          Vld1,
   input  logic [AW-1:0] Addr1,
   input  logic [DW-1:0] Data1,
   output logic          Rdy0,
   output logic          Rdy1,
   output logic          RegWr,
   output logic [AW-1:0] RW,
   output logic [DW-1:0] BusW,
   input  logic [AW-1:0] RA,
   input  logic [AW-1:0] RB,
   output logic          Stall
`ifdef REGARB_FWD_EN
   ,
   output logic          FwdAVld,
   output logic          FwdBVld,
   output logic [DW-1:0] FwdA,
   output logic [DW-1:0] FwdB
`endif
);

   // Holding slots
   logic          pend0, pend1;
   logic [AW-1:0] addr0Q, addr1Q;
   logic [DW-1:0] data0Q, data1Q;
   // rrPtr: 0 -> src0 wins the next tie. ageBit: 1 -> slot1 is the older entry.
   logic          rrPtr;
   logic          ageBit;
   // Both slots were loaded on the same edge and the tie is not yet resolved.
   logic          tieQ;

   logic grant0, grant1;
   logic load0, load1;
   logic nextPend0, nextPend1;

   // Grant selection from slot state: lone slot, else tie by rrPtr, else oldest.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (pend0 && pend1) begin
         if (tieQ) begin
            grant0 = !rrPtr;
            grant1 = rrPtr;
         end else begin
            grant0 = !ageBit;
            grant1 = ageBit;
         end
      end else begin
         grant0 = pend0;
         grant1 = pend1;
      end
   end

   // Slot readiness, accepted loads (address 0 is accepted but dropped) and slot occupancy.
   always_comb begin
      Rdy0      = !pend0 || grant0;
      Rdy1      = !pend1 || grant1;
      load0     = Vld0 && Rdy0 && (Addr0 != '0);
      load1     = Vld1 && Rdy1 && (Addr1 != '0);
      nextPend0 = load0 || (pend0 && !grant0);
      nextPend1 = load1 || (pend1 && !grant1);
   end

   // Slot registers, arrival-order tracking and round-robin pointer.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         pend0  <= 1'b0;
         pend1  <= 1'b0;
         addr0Q <= '0;
         addr1Q <= '0;
         data0Q <= '0;
         data1Q <= '0;
         rrPtr  <= 1'b0;
         ageBit <= 1'b0;
         tieQ   <= 1'b0;
      end else begin
         pend0 <= nextPend0;
         pend1 <= nextPend1;
         if (load0) begin
            addr0Q <= Addr0;
            data0Q <= Data0;
         end
         if (load1) begin
            addr1Q <= Addr1;
            data1Q <= Data1;
         end
         // A tie is always resolved in the cycle it is seen, so toggle there.
         if (pend0 && pend1 && tieQ)
            rrPtr <= !rrPtr;
         tieQ <= load0 && load1;
         // A fresh load behind a still-pending entry makes the other slot the older one.
         if (load0 && !load1)
            ageBit <= 1'b1;
         else if (load1 && !load0)
            ageBit <= 1'b0;
      end
   end

   // Write stage: register the granted slot onto the write port; hold RW/BusW when idle.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         RegWr <= 1'b0;
         RW    <= '0;
         BusW  <= '0;
      end else if (grant0) begin
         RegWr <= 1'b1;
         RW    <= addr0Q;
         BusW  <= data0Q;
      end else if (grant1) begin
         RegWr <= 1'b1;
         RW    <= addr1Q;
         BusW  <= data1Q;
      end else begin
         RegWr <= 1'b0;
      end
   end

   logic slotHitA, slotHitB, wsHitA, wsHitB;

   // Scoreboard: match read addresses against pending slots and the write stage ($0 never hits).
   always_comb begin
      slotHitA = (RA != '0) && ((pend0 && (addr0Q == RA)) || (pend1 && (addr1Q == RA)));
      slotHitB = (RB != '0) && ((pend0 && (addr0Q == RB)) || (pend1 && (addr1Q == RB)));
      wsHitA   = (RA != '0) && RegWr && (RW == RA);
      wsHitB   = (RB != '0) && RegWr && (RW == RB);
   end

`ifdef REGARB_FWD_EN
   // Write-stage-only hits are forwarded from BusW; slot hits still stall.
   always_comb begin
      FwdAVld = wsHitA && !slotHitA;
      FwdBVld = wsHitB && !slotHitB;
      FwdA    = FwdAVld ? BusW : '0;
      FwdB    = FwdBVld ? BusW : '0;
      Stall   = slotHitA || slotHitB;
   end
`else
   // Without forwarding every hit, including the write stage, stalls decode.
   always_comb begin
      Stall = slotHitA || slotHitB || wsHitA || wsHitB;
   end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
// Directed steps followed by random traffic, each cycle checked against a
// timestamp-based reference model of the two holding slots and write port.
// Builds with or without REGARB_FWD_EN.
module tb_regfile_write_arbiter;
   localparam int AW = 5;
   localparam int DW = 32;

   logic          Clk = 1'b0;
   logic          Rst;
   logic          Vld0, Vld1;
   logic [AW-1:0] Addr0, Addr1;
   logic [DW-1:0] Data0, Data1;
   logic          Rdy0, Rdy1;
   logic          RegWr;
   logic [AW-1:0] RW;
   logic [DW-1:0] BusW;
   logic [AW-1:0] RA, RB;
   logic          Stall;
`ifdef REGARB_FWD_EN
   logic          FwdAVld, FwdBVld;
   logic [DW-1:0] FwdA, FwdB;
`endif

   // Clock
   always #5 Clk = ~Clk;

   regfile_write_arbiter #(.AW(AW), .DW(DW)) dut (
      .Clk(Clk), .Rst(Rst),
      .Vld0(Vld0), .Addr0(Addr0), .Data0(Data0),
      .Vld1(Vld1), .Addr1(Addr1), .Data1(Data1),
      .Rdy0(Rdy0), .Rdy1(Rdy1),
      .RegWr(RegWr), .RW(RW), .BusW(BusW),
      .RA(RA), .RB(RB), .Stall(Stall)
`ifdef REGARB_FWD_EN
      , .FwdAVld(FwdAVld), .FwdBVld(FwdBVld), .FwdA(FwdA), .FwdB(FwdB)
`endif
   );

   int errors = 0;
   int checks = 0;

   // Reference model: each pending slot remembers the cycle it was loaded;
   // the oldest timestamp wins, equal timestamps are settled by a round-robin bit.
   logic          mPend[2];
   logic [AW-1:0] mAddr[2];
   logic [DW-1:0] mData[2];
   int            mTime[2];
   logic          mRr;
   logic          mRegWr;
   logic [AW-1:0] mRw;
   logic [DW-1:0] mBusW;
   int            cyc = 0;
   logic [DW-1:0] dutRf[32];

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int mGrant();
      if (mPend[0] && mPend[1]) begin
         if (mTime[0] < mTime[1]) return 0;
         if (mTime[1] < mTime[0]) return 1;
         return mRr ? 1 : 0;
      end
      if (mPend[0]) return 0;
      if (mPend[1]) return 1;
      return -1;
   endfunction

   function automatic logic mSlotHit(input logic [AW-1:0] x);
      return (x != 0) && ((mPend[0] && mAddr[0] == x) || (mPend[1] && mAddr[1] == x));
   endfunction

   function automatic logic mWsHit(input logic [AW-1:0] x);
      return (x != 0) && mRegWr && (mRw == x);
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 2; i++) begin
         mPend[i] = 1'b0;
         mAddr[i] = '0;
         mData[i] = '0;
         mTime[i] = 0;
      end
      mRr    = 1'b0;
      mRegWr = 1'b0;
      mRw    = '0;
      mBusW  = '0;
   endtask

   // One clock: check every output against the model, then advance both across the edge.
   task automatic step();
      int            g;
      logic          rdy[2];
      logic          vld[2];
      logic [AW-1:0] a[2];
      logic [DW-1:0] d[2];
      logic          expStall;
      logic          tie;
      #1;
      g = mGrant();
      rdy[0] = !mPend[0] || (g == 0);
      rdy[1] = !mPend[1] || (g == 1);
`ifdef REGARB_FWD_EN
      expStall = mSlotHit(RA) || mSlotHit(RB);
      chk("FwdAVld", DW'(FwdAVld), DW'(mWsHit(RA) && !mSlotHit(RA)));
      chk("FwdBVld", DW'(FwdBVld), DW'(mWsHit(RB) && !mSlotHit(RB)));
      chk("FwdA", FwdA, (mWsHit(RA) && !mSlotHit(RA)) ? mBusW : '0);
      chk("FwdB", FwdB, (mWsHit(RB) && !mSlotHit(RB)) ? mBusW : '0);
`else
      expStall = mSlotHit(RA) || mSlotHit(RB) || mWsHit(RA) || mWsHit(RB);
`endif
      chk("Rdy0", DW'(Rdy0), DW'(rdy[0]));
      chk("Rdy1", DW'(Rdy1), DW'(rdy[1]));
      chk("Stall", DW'(Stall), DW'(expStall));
      chk("RegWr", DW'(RegWr), DW'(mRegWr));
      chk("RW", DW'(RW), DW'(mRw));
      chk("BusW", BusW, mBusW);
      if (RegWr === 1'b1) dutRf[RW] = BusW;
      vld[0] = Vld0; a[0] = Addr0; d[0] = Data0;
      vld[1] = Vld1; a[1] = Addr1; d[1] = Data1;
      @(posedge Clk);
      if (Rst) begin
         modelReset();
      end else begin
         if (g >= 0) begin
            tie    = mPend[0] && mPend[1] && (mTime[0] == mTime[1]);
            mRegWr = 1'b1;
            mRw    = mAddr[g];
            mBusW  = mData[g];
            mPend[g] = 1'b0;
            if (tie) mRr = !mRr;
         end else begin
            mRegWr = 1'b0;
         end
         for (int i = 0; i < 2; i++) begin
            if (vld[i] && rdy[i] && a[i] != 0) begin
               mPend[i] = 1'b1;
               mAddr[i] = a[i];
               mData[i] = d[i];
               mTime[i] = cyc;
            end
         end
      end
      cyc++;
      @(negedge Clk);
   endtask

   task automatic idleInputs();
      Vld0 = 1'b0; Vld1 = 1'b0;
      Addr0 = '0; Addr1 = '0;
      Data0 = '0; Data1 = '0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) dutRf[i] = '0;
      idleInputs();
      RA = '0; RB = '0;

      // Test 1: reset for two cycles, then idle outputs
      Rst = 1'b1;
      @(posedge Clk);
      @(posedge Clk);
      modelReset();
      @(negedge Clk);
      Rst = 1'b0;
      RA = 5'd1; RB = 5'd2;
      #1;
      chk("rst_RegWr", DW'(RegWr), '0);
      chk("rst_RW", DW'(RW), '0);
      chk("rst_BusW", BusW, '0);
      chk("rst_Rdy0", DW'(Rdy0), DW'(1'b1));
      chk("rst_Rdy1", DW'(Rdy1), DW'(1'b1));
      chk("rst_Stall", DW'(Stall), '0);
      step();

      // Test 2: single src0 write, visible one edge later for one cycle
      Vld0 = 1'b1; Addr0 = 5'd5; Data0 = 32'hDEADBEEF;
      step();
      idleInputs();
      step();
      chk("t2_RegWr", DW'(RegWr), DW'(1'b1));
      chk("t2_RW", DW'(RW), DW'(5'd5));
      chk("t2_BusW", BusW, 32'hDEADBEEF);
      step();
      chk("t2_RegWr_off", DW'(RegWr), '0);

      // Test 3: same-address tie, src0 first, final value from src1; next tie favours src1
      Vld0 = 1'b1; Addr0 = 5'd3; Data0 = 32'hA0A0A0A0;
      Vld1 = 1'b1; Addr1 = 5'd3; Data1 = 32'hB1B1B1B1;
      step();
      idleInputs();
      step();
      chk("t3_first_BusW", BusW, 32'hA0A0A0A0);
      step();
      step();
      chk("t3_reg3", dutRf[3], 32'hB1B1B1B1);
      Vld0 = 1'b1; Addr0 = 5'd11; Data0 = 32'h11;
      Vld1 = 1'b1; Addr1 = 5'd12; Data1 = 32'h12;
      step();
      idleInputs();
      step();
      chk("t3_tie2_first", DW'(RW), DW'(5'd12));
      step();
      step();

      // Test 4: write to $0 is accepted and dropped
      Vld1 = 1'b1; Addr1 = 5'd0; Data1 = 32'h1234; RA = 5'd0; RB = 5'd0;
      #1;
      chk("t4_Rdy1", DW'(Rdy1), DW'(1'b1));
      step();
      idleInputs();
      step();
      chk("t4_RegWr", DW'(RegWr), '0);
      chk("t4_Stall", DW'(Stall), '0);

      // Test 5: pending write to r7 stalls RA=7 until retired
      Vld0 = 1'b1; Addr0 = 5'd7; Data0 = 32'h7777_0007; RA = 5'd7;
      step();
      idleInputs();
      #1;
      chk("t5_slot_stall", DW'(Stall), DW'(1'b1));
      step();
`ifdef REGARB_FWD_EN
      chk("t5_ws_stall", DW'(Stall), '0);
      chk("t5_FwdAVld", DW'(FwdAVld), DW'(1'b1));
      chk("t5_FwdA", FwdA, 32'h7777_0007);
`else
      chk("t5_ws_stall", DW'(Stall), DW'(1'b1));
`endif
      step();
      chk("t5_retired", DW'(Stall), '0);

      // Test 6: both slots full, then reset discards them
      RA = 5'd9; RB = 5'd10;
      Vld0 = 1'b1; Addr0 = 5'd9; Data0 = 32'h9;
      Vld1 = 1'b1; Addr1 = 5'd10; Data1 = 32'hA;
      step();
      idleInputs();
      Rst = 1'b1;
      step();
      Rst = 1'b0;
      #1;
      chk("t6_Rdy0", DW'(Rdy0), DW'(1'b1));
      chk("t6_Rdy1", DW'(Rdy1), DW'(1'b1));
      chk("t6_RegWr", DW'(RegWr), '0);
      chk("t6_Stall", DW'(Stall), '0);
      step();
      chk("t6_no_write", DW'(RegWr), '0);

      // Random traffic over a small address range to provoke contention and hazards
      for (int n = 0; n < 800; n++) begin
         Rst   = ($urandom_range(0, 99) == 0);
         Vld0  = ($urandom_range(0, 3) != 0);
         Vld1  = ($urandom_range(0, 3) != 0);
         Addr0 = AW'($urandom_range(0, 7));
         Addr1 = AW'($urandom_range(0, 7));
         Data0 = $urandom;
         Data1 = $urandom;
         RA    = AW'($urandom_range(0, 7));
         RB    = AW'($urandom_range(0, 7));
         step();
      end
      Rst = 1'b0;
      idleInputs();
      for (int n = 0; n < 4; n++) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
